ame_equation_builder: RTL and testbench

Accumulates the per-pixel gradient statistics of one affine motion-estimation block into the 6×7 normal-equation system (A | B) consumed by the AME linear solver. It sits directly upstream of the solver and drives its `comp_init`/`comp_data`/`affine_param6` inputs. It holds the system stable until the solver reports done.

---
 rtl/ame_pkg.sv | 47 ++++
 rtl/ame_coef_gen.sv | 69 ++++++
 rtl/ame_equation_builder.sv | 192 +++++++++++++++++++
 tb/tb_ame_equation_builder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ame_pkg.sv
// Shared definitions for the affine motion-estimation equation builder.
//   state_t       : control FSM states
//   C_*           : coefficient slot indices (slot meaning differs in 4-param mode)
//   B_IDX         : column of comp_data that carries the right-hand side B
//   PIPE_DEPTH    : cycles from an accepted beat to its accumulator update
//   tri_idx/elem_idx : map a (row, col) of the 6x7 system onto the 27 MACs
package ame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam int NUM_COEF   = 6;
  localparam int NUM_ELEM   = 7;
  localparam int B_IDX      = 6;
  localparam int PIPE_DEPTH = 3;
  localparam int NUM_TRI    = 21;  // upper triangle of the 6x6 A, diagonal included
  localparam int NUM_MAC    = 27;  // 21 A terms + 6 B terms

  localparam int C_GX  = 0;
  localparam int C_GXX = 1;
  localparam int C_GY  = 2;
  localparam int C_GYX = 3;
  localparam int C_GXY = 4;
  localparam int C_GYY = 5;

  // Row-major packing of the upper triangle (i <= j).
  function automatic int tri_idx(input int i, input int j);
    return i * NUM_COEF - (i * (i - 1)) / 2 + (j - i);
  endfunction

  // MAC slot for any element of the system; lower-triangle elements fold
  // onto their mirror so A stays symmetric by construction.
  function automatic int elem_idx(input int i, input int j);
    if (j == B_IDX)
      return NUM_TRI + i;
    else if (i <= j)
      return tri_idx(i, j);
    else
      return tri_idx(j, i);
  endfunction

endpackage

// File: rtl/ame_coef_gen.sv
// Registered coefficient stage: maps one pixel's gradients and position to
// the six regression coefficients c0..c5 of the selected affine model.
//   clk_i           : clock
//   en_i            : load a new sample (accepted beat)
//   affine_param6_i : 1 = 6-parameter model, 0 = 4-parameter model
//   gx_i, gy_i      : signed gradients
//   x_i, y_i        : unsigned pixel position inside the block
//   c_o             : registered coefficients, signed, COEF_BITS wide
module ame_coef_gen
  import ame_pkg::*;
#(
  parameter int GRAD_BITS = 16,
  parameter int POS_BITS  = 7,
  parameter int COEF_BITS = GRAD_BITS + POS_BITS + 2
) (
  input  logic                                 clk_i,
  input  logic                                 en_i,
  input  logic                                 affine_param6_i,
  input  logic signed [GRAD_BITS-1:0]          gx_i,
  input  logic signed [GRAD_BITS-1:0]          gy_i,
  input  logic        [POS_BITS-1:0]           x_i,
  input  logic        [POS_BITS-1:0]           y_i,
  output logic        [NUM_COEF-1:0][COEF_BITS-1:0] c_o
);

  // COEF_BITS leaves one bit for the sign of gx*x and one more for the
  // sum/difference formed in the 4-parameter model, so nothing truncates.
  logic signed [COEF_BITS-1:0] gx_e;
  logic signed [COEF_BITS-1:0] gy_e;
  logic signed [COEF_BITS-1:0] x_e;
  logic signed [COEF_BITS-1:0] y_e;
  logic signed [COEF_BITS-1:0] gxx;
  logic signed [COEF_BITS-1:0] gyx;
  logic signed [COEF_BITS-1:0] gxy;
  logic signed [COEF_BITS-1:0] gyy;

  assign gx_e = COEF_BITS'(gx_i);
  assign gy_e = COEF_BITS'(gy_i);
  assign x_e  = $signed({{(COEF_BITS - POS_BITS){1'b0}}, x_i});
  assign y_e  = $signed({{(COEF_BITS - POS_BITS){1'b0}}, y_i});

  assign gxx = gx_e * x_e;
  assign gyx = gy_e * x_e;
  assign gxy = gx_e * y_e;
  assign gyy = gy_e * y_e;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (affine_param6_i) begin
        c_o[C_GX]  <= gx_e;
        c_o[C_GXX] <= gxx;
        c_o[C_GY]  <= gy_e;
        c_o[C_GYX] <= gyx;
        c_o[C_GXY] <= gxy;
        c_o[C_GYY] <= gyy;
      end else begin
        // 4-parameter model: the first two slots are unused so that the
        // solver sees the same 6x6 layout with rows/cols 0-1 forced to zero.
        c_o[C_GX]  <= '0;
        c_o[C_GXX] <= '0;
        c_o[C_GY]  <= gx_e;
        c_o[C_GYX] <= gy_e;
        c_o[C_GXY] <= gxx + gyy;
        c_o[C_GYY] <= gyx - gxy;
      end
    end
  end

endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates per-pixel gradient statistics of one block into the 6x7
// normal-equation system (A | B) and hands it to the linear solver.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   affine_param6_i   : model select, sampled on the first beat of a block
//   s_valid_i/s_ready_o/s_last_i : sample stream handshake
//   s_gx_i, s_gy_i, s_diff_i     : signed gradients and residual
//   s_x_i, s_y_i      : pixel position
//   comp_init_o       : one-cycle pulse, comp_data_o holds a complete system
//   comp_done_i       : solver finished (honoured only while waiting for it)
//   affine_param6_o   : model latched for the current block
//   comp_data_o       : [i][j<6] = A_ij, [i][6] = B_i
module ame_equation_builder
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int GRAD_BITS      = 16,
  parameter int POS_BITS       = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          affine_param6_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic                          s_last_i,
  input  logic signed [GRAD_BITS-1:0]   s_gx_i,
  input  logic signed [GRAD_BITS-1:0]   s_gy_i,
  input  logic signed [GRAD_BITS-1:0]   s_diff_i,
  input  logic        [POS_BITS-1:0]    s_x_i,
  input  logic        [POS_BITS-1:0]    s_y_i,
  output logic                          comp_init_o,
  input  logic                          comp_done_i,
  output logic                          affine_param6_o,
  output logic [NUM_COEF-1:0][NUM_ELEM-1:0][COMP_DATA_BITS-1:0] comp_data_o
);

  localparam int COEF_BITS = GRAD_BITS + POS_BITS + 2;
  localparam int PROD_BITS = 2 * COEF_BITS;
  localparam int CNT_BITS  = $clog2(PIPE_DEPTH);

  state_t                state_reg;
  logic [CNT_BITS-1:0]   drain_cnt_reg;
  logic                  mode_reg;
  logic                  ready_reg;
  logic                  init_reg;
  logic                  beat;
  logic                  first_beat;
  logic                  coef_mode;

  logic                  v_s1_reg;
  logic                  v_s2_reg;
  logic signed [GRAD_BITS-1:0] diff_s1_reg;
  logic signed [COEF_BITS-1:0] diff_ext;
  logic [NUM_COEF-1:0][COEF_BITS-1:0] coef;
  logic [COMP_DATA_BITS-1:0] acc_w [NUM_MAC];

  assign beat       = s_valid_i & ready_reg;
  assign first_beat = beat & (state_reg == ST_IDLE);
  // The first beat of a block must already use the incoming model select;
  // later beats use the latched copy so the model cannot change mid-block.
  assign coef_mode  = (state_reg == ST_IDLE) ? affine_param6_i : mode_reg;

  assign s_ready_o       = ready_reg;
  assign comp_init_o     = init_reg;
  assign affine_param6_o = mode_reg;

  // Control FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      ready_reg     <= 1'b1;
      init_reg      <= 1'b0;
      mode_reg      <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      init_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_ACCUM: begin
          if (beat) begin
            if (first_beat)
              mode_reg <= affine_param6_i;
            if (s_last_i) begin
              state_reg     <= ST_DRAIN;
              ready_reg     <= 1'b0;
              drain_cnt_reg <= CNT_BITS'(PIPE_DEPTH - 1);
            end else begin
              state_reg <= ST_ACCUM;
            end
          end
        end
        ST_DRAIN: begin
          // The last beat reaches the accumulators on the final DRAIN cycle.
          if (drain_cnt_reg == '0) begin
            state_reg <= ST_ISSUE;
            init_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 1'b1;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (comp_done_i) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Pipeline valids
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_s1_reg <= 1'b0;
      v_s2_reg <= 1'b0;
    end else begin
      v_s1_reg <= beat;
      v_s2_reg <= v_s1_reg;
    end
  end

  // Residual travels alongside the coefficient stage.
  always_ff @(posedge clk_i) begin
    if (beat)
      diff_s1_reg <= s_diff_i;
  end

  assign diff_ext = COEF_BITS'(diff_s1_reg);

  ame_coef_gen #(
    .GRAD_BITS (GRAD_BITS),
    .POS_BITS  (POS_BITS),
    .COEF_BITS (COEF_BITS)
  ) u_coef_gen (
    .clk_i           (clk_i),
    .en_i            (beat),
    .affine_param6_i (coef_mode),
    .gx_i            (s_gx_i),
    .gy_i            (s_gy_i),
    .x_i             (s_x_i),
    .y_i             (s_y_i),
    .c_o             (coef)
  );

  // Multiply-accumulate array: one MAC per upper-triangle A term and per B
  // term; lower-triangle outputs are wired to their mirror.
  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_ELEM; gj++) begin : g_col
      if (gj == B_IDX || gj >= gi) begin : g_mac
        localparam int K = elem_idx(gi, gj);
        logic signed [COEF_BITS-1:0]  opnd_b;
        logic signed [PROD_BITS-1:0]  opnd_a_ext;
        logic signed [PROD_BITS-1:0]  opnd_b_ext;
        logic signed [PROD_BITS-1:0]  prod_reg;
        logic [COMP_DATA_BITS-1:0]    acc_reg;

        if (gj == B_IDX) begin : g_b
          assign opnd_b = diff_ext;
        end else begin : g_a
          assign opnd_b = $signed(coef[gj]);
        end

        assign opnd_a_ext = PROD_BITS'($signed(coef[gi]));
        assign opnd_b_ext = PROD_BITS'(opnd_b);

        always_ff @(posedge clk_i) begin
          if (v_s1_reg)
            prod_reg <= opnd_a_ext * opnd_b_ext;
        end

        // Wraps modulo 2^COMP_DATA_BITS by design; the pipeline is empty
        // whenever a block starts, so clearing never drops a product.
        always_ff @(posedge clk_i) begin
          if (rst_i || first_beat)
            acc_reg <= '0;
          else if (v_s2_reg)
            acc_reg <= acc_reg + COMP_DATA_BITS'(prod_reg);
        end

        assign acc_w[K] = acc_reg;
      end

      assign comp_data_o[gi][gj] = acc_w[elem_idx(gi, gj)];
    end
  end

endmodule

// File: tb/tb_ame_equation_builder.sv
module tb_ame_equation_builder;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    mode_in = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic                    s_last = 1'b0;
  logic signed [15:0]      gx_in = '0;
  logic signed [15:0]      gy_in = '0;
  logic signed [15:0]      diff_in = '0;
  logic [6:0]              x_in = '0;
  logic [6:0]              y_in = '0;
  logic                    comp_init;
  logic                    comp_done = 1'b0;
  logic                    param6;
  logic [5:0][6:0][63:0]   comp_data;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ame_equation_builder dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .affine_param6_i (mode_in),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready),
    .s_last_i        (s_last),
    .s_gx_i          (gx_in),
    .s_gy_i          (gy_in),
    .s_diff_i        (diff_in),
    .s_x_i           (x_in),
    .s_y_i           (y_in),
    .comp_init_o     (comp_init),
    .comp_done_i     (comp_done),
    .affine_param6_o (param6),
    .comp_data_o     (comp_data)
  );

  typedef struct {
    bit     mode;
    int     gx;
    int     gy;
    int     x;
    int     y;
    int     diff;
    int     ri;
    int     cj;
    longint exp;
  } vec_t;

  vec_t vecs[20];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(exp));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns one cycle after it is accepted.
  task automatic send_beat(input bit mode, input int gx, input int gy, input int x,
                           input int y, input int diff, input bit last);
    int k;
    mode_in = mode;
    gx_in   = 16'(gx);
    gy_in   = 16'(gy);
    x_in    = 7'(x);
    y_in    = 7'(y);
    diff_in = 16'(diff);
    s_last  = last;
    s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 50) begin
      step();
      k++;
    end
    if (!s_ready) check("ready_timeout", {63'd0, s_ready}, 64'd1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Counts cycles from the last beat (cycle t) until comp_init is seen.
  task automatic wait_init(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (comp_init) begin
        lat = k;
        break;
      end
      step();
    end
  endtask

  // From the ISSUE cycle: move to WAIT, pulse done, expect ready next cycle.
  task automatic finish_block();
    step();
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    check("ready_after_done", {63'd0, s_ready}, 64'd1);
  endtask

  function automatic logic [63:0] zero_rows01();
    logic [63:0] z;
    z = '0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        if (i < 2 || j < 2) z = z | comp_data[i][j];
    return z;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [5:0][6:0][63:0] snap;
    logic bad;
    longint a55, b5, a05;
    longint c0, c5;

    // c = [1,3,2,6,4,8]
    vecs[0]  = '{1'b1,  1, 2,  3, 4,  5, 0, 0, 1};
    vecs[1]  = '{1'b1,  1, 2,  3, 4,  5, 0, 1, 3};
    vecs[2]  = '{1'b1,  1, 2,  3, 4,  5, 1, 1, 9};
    vecs[3]  = '{1'b1,  1, 2,  3, 4,  5, 0, 5, 8};
    vecs[4]  = '{1'b1,  1, 2,  3, 4,  5, 5, 5, 64};
    vecs[5]  = '{1'b1,  1, 2,  3, 4,  5, 0, 6, 5};
    vecs[6]  = '{1'b1,  1, 2,  3, 4,  5, 5, 6, 40};
    // 4-param: c = [0,0,1,2,11,2]
    vecs[7]  = '{1'b0,  1, 2,  3, 4,  5, 4, 4, 121};
    vecs[8]  = '{1'b0,  1, 2,  3, 4,  5, 2, 4, 11};
    vecs[9]  = '{1'b0,  1, 2,  3, 4,  5, 4, 6, 55};
    vecs[10] = '{1'b0,  1, 2,  3, 4,  5, 3, 5, 4};
    vecs[11] = '{1'b0,  1, 2,  3, 4,  5, 2, 6, 5};
    // 6-param: c = [-3,-30,5,50,0,0]
    vecs[12] = '{1'b1, -3, 5, 10, 0, -7, 0, 1, 90};
    vecs[13] = '{1'b1, -3, 5, 10, 0, -7, 1, 3, -1500};
    vecs[14] = '{1'b1, -3, 5, 10, 0, -7, 1, 6, 210};
    vecs[15] = '{1'b1, -3, 5, 10, 0, -7, 0, 3, -150};
    // 4-param: c = [0,0,-3,5,-20,56]
    vecs[16] = '{1'b0, -3, 5, 10, 2, -7, 4, 5, -1120};
    vecs[17] = '{1'b0, -3, 5, 10, 2, -7, 5, 6, -392};
    vecs[18] = '{1'b0, -3, 5, 10, 2, -7, 2, 5, -168};
    vecs[19] = '{1'b0, -3, 5, 10, 2, -7, 5, 5, 3136};

    // Reset state
    repeat (3) step();
    check("rst_ready", {63'd0, s_ready}, 64'd1);
    check("rst_init", {63'd0, comp_init}, 64'd0);
    check("rst_param6", {63'd0, param6}, 64'd0);
    check("rst_data", {63'd0, |comp_data}, 64'd0);
    rst = 1'b0;
    step();

    // Single-beat blocks from the vector table
    for (int v = 0; v < 20; v++) begin
      send_beat(vecs[v].mode, vecs[v].gx, vecs[v].gy, vecs[v].x, vecs[v].y, vecs[v].diff, 1'b1);
      wait_init(lat);
      check("latency", 64'(lat), 64'd4);
      check("elem", comp_data[vecs[v].ri][vecs[v].cj], vecs[v].exp);
      if (vecs[v].cj < 6)
        check("elem_mirror", comp_data[vecs[v].cj][vecs[v].ri], vecs[v].exp);
      check("param6", {63'd0, param6}, {63'd0, vecs[v].mode});
      if (!vecs[v].mode)
        check("zero_rows01", zero_rows01(), 64'd0);
      $display("vec %0d mode=%0d gx=%0d gy=%0d x=%0d y=%0d diff=%0d elem[%0d][%0d]=%0d",
               v, vecs[v].mode, vecs[v].gx, vecs[v].gy, vecs[v].x, vecs[v].y, vecs[v].diff,
               vecs[v].ri, vecs[v].cj, $signed(comp_data[vecs[v].ri][vecs[v].cj]));
      finish_block();
    end

    // Multi-beat block with bubbles: c = [-1,-1,0,0,-1,0]
    for (int b = 0; b < 16; b++) begin
      send_beat(1'b1, -1, 0, 1, 1, 2, b == 15);
      if (b < 15) step();
    end
    check("ready_drain", {63'd0, s_ready}, 64'd0);
    wait_init(lat);
    check("multi_latency", 64'(lat), 64'd4);
    check("multi_A00", comp_data[0][0], 64'd16);
    check("multi_B0", comp_data[0][6], -64'sd32);
    check("multi_A11", comp_data[1][1], 64'd16);
    check("multi_A14", comp_data[1][4], 64'd16);
    check("multi_A22", comp_data[2][2], 64'd0);
    $display("multi-beat block: A00=%0d B0=%0d A14=%0d",
             $signed(comp_data[0][0]), $signed(comp_data[0][6]), $signed(comp_data[1][4]));
    step();
    check("ready_wait", {63'd0, s_ready}, 64'd0);
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    check("multi_ready_after_done", {63'd0, s_ready}, 64'd1);

    // Handshake: done during ISSUE ignored; stall in WAIT; done releases
    send_beat(1'b1, 1, 2, 3, 4, 5, 1'b1);
    wait_init(lat);
    check("hs_latency", 64'(lat), 64'd4);
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    check("done_in_issue_ignored", {63'd0, s_ready}, 64'd0);
    snap = comp_data;
    bad = 1'b0;
    gx_in   = 16'sd77;
    s_last  = 1'b1;
    s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_ready || comp_init || comp_data !== snap) bad = 1'b1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("wait_stable", {63'd0, bad}, 64'd0);
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    check("hs_ready_after_done", {63'd0, s_ready}, 64'd1);
    step();
    step();
    check("idle_hold_data", {63'd0, comp_data !== snap}, 64'd0);
    check("idle_hold_param6", {63'd0, param6}, 64'd1);
    $display("handshake block: A55=%0d held through WAIT and IDLE", $signed(comp_data[5][5]));

    // Reset in the middle of a block
    for (int b = 0; b < 5; b++)
      send_beat(1'b1, 100, 100, 5, 5, 9, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", {63'd0, s_ready}, 64'd1);
    check("midrst_param6", {63'd0, param6}, 64'd0);
    check("midrst_data", {63'd0, |comp_data}, 64'd0);
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (comp_init || (|comp_data)) bad = 1'b1;
      step();
    end
    check("midrst_no_init", {63'd0, bad}, 64'd0);
    send_beat(1'b1, 1, 2, 3, 4, 5, 1'b1);
    wait_init(lat);
    check("postrst_latency", 64'(lat), 64'd4);
    check("postrst_A00", comp_data[0][0], 64'd1);
    check("postrst_B5", comp_data[5][6], 64'd40);
    $display("post-reset block: A00=%0d B5=%0d", $signed(comp_data[0][0]), $signed(comp_data[5][6]));
    finish_block();

    // Long full-scale block against a 64-bit modular model
    c0  = 32767;
    c5  = 64'(32767 * 127);
    a55 = 0;
    b5  = 0;
    a05 = 0;
    for (int n = 0; n < 4096; n++) begin
      send_beat(1'b1, 32767, 32767, 127, 127, -32768, n == 4095);
      a55 += c5 * c5;
      b5  += c5 * (-32768);
      a05 += c0 * c5;
    end
    wait_init(lat);
    check("wrap_latency", 64'(lat), 64'd4);
    check("wrap_A55", comp_data[5][5], a55);
    check("wrap_B5", comp_data[5][6], b5);
    check("wrap_A50", comp_data[5][0], a05);
    $display("full-scale block: A55=%0d B5=%0d", $signed(comp_data[5][5]), $signed(comp_data[5][6]));
    finish_block();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
